// File: rtl/branch_select_check.sv
// branch_select_check
//   Forces the instruction-select field to all-ones on a taken jump. A jump is
//   taken when it is forced by the unconditional enable, or when cond_mode is
//   set and the selected status flag, optionally inverted, is 1. The result is
//   registered with one cycle of latency. After each taken jump the block
//   holds flush for FLUSH_CYCLES cycles and refuses new input during that
//   window. It also keeps a saturating count of taken jumps.
// Ports
//   clk, reset            : clock, async active-high reset
//   valid_in / ready_out  : input handshake (accept = valid_in & ready_out)
//   instruct              : incoming select field
//   enabled               : unconditional jump
//   cond_mode/sel/inv     : conditional jump controls
//   cond_flags            : ALU status flags
//   instructA             : registered select result
//   valid_out             : one-cycle pulse per accepted input
//   taken                 : the accepted input was a taken jump
//   flush                 : flush request to fetch/decode
//   taken_count           : saturating taken-jump count
module branch_select_check #(
  parameter int WIDTH        = 2,
  parameter int NUM_COND     = 4,
  parameter int SEL_W        = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [WIDTH-1:0]    instruct,
  input  logic                enabled,
  input  logic                cond_mode,
  input  logic [SEL_W-1:0]    cond_sel,
  input  logic                cond_inv,
  input  logic [NUM_COND-1:0] cond_flags,
  output logic [WIDTH-1:0]    instructA,
  output logic                valid_out,
  output logic                taken,
  output logic                flush,
  output logic [CNT_W-1:0]    taken_count
);

  localparam int NSEL = 2**SEL_W;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state, state_n;
  logic [FC_W-1:0]   fcnt, fcnt_n;
  logic [NSEL-1:0]   flags_pad;
  logic              flag, jump, accept;

  // The flag vector is padded out to the full select range. Padding bits are 0,
  // so an out-of-range cond_sel reduces flag to cond_inv, and indexing never
  // reads an undriven bit.
  for (genvar i = 0; i < NSEL; i++) begin : g_pad
    if (i < NUM_COND) begin : g_flag
      assign flags_pad[i] = cond_flags[i];
    end else begin : g_zero
      assign flags_pad[i] = 1'b0;
    end
  end

  assign flag      = flags_pad[cond_sel] ^ cond_inv;
  assign jump      = enabled | (cond_mode & flag);
  assign ready_out = (state == RUN);
  assign flush     = (state == FLUSH);
  assign accept    = valid_in & ready_out;

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    case (state)
      RUN: begin
        if (accept && jump) begin
          state_n = FLUSH;
          fcnt_n  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt == '0) state_n = RUN;
        else            fcnt_n  = fcnt - FC_W'(1);
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instructA   <= '0;
      valid_out   <= 1'b0;
      taken       <= 1'b0;
      taken_count <= '0;
    end else begin
      valid_out <= accept;
      taken     <= accept & jump;
      if (accept) instructA <= instruct | {WIDTH{jump}};
      if (accept && jump && (taken_count != {CNT_W{1'b1}}))
        taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_select_check.sv
// Bench for branch_select_check. It runs two instances on shared stimulus:
//   u0 : default parameters (WIDTH=2, NUM_COND=4, FLUSH_CYCLES=2, CNT_W=8)
//   u1 : WIDTH=5, NUM_COND=3, FLUSH_CYCLES=4, CNT_W=3
// A behavioural model tracks the remaining flush cycles and the jump count as
// plain integers. A negedge process compares both instances against the model
// on every cycle. The directed steps also pin hand-computed literal values.
module tb_branch_select_check;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vi = 1'b0, en = 1'b0, mode = 1'b0, inv = 1'b0;
  logic [4:0] ins = '0;
  logic [1:0] sel = '0;
  logic [3:0] flags = '0;

  logic       rdy0, vo0, tk0, fl0;
  logic [1:0] ia0;
  logic [7:0] cnt0;
  logic       rdy1, vo1, tk1, fl1;
  logic [4:0] ia1;
  logic [2:0] cnt1;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  branch_select_check u0 (
    .clk(clk), .reset(reset), .valid_in(vi), .ready_out(rdy0),
    .instruct(ins[1:0]), .enabled(en), .cond_mode(mode), .cond_sel(sel),
    .cond_inv(inv), .cond_flags(flags), .instructA(ia0), .valid_out(vo0),
    .taken(tk0), .flush(fl0), .taken_count(cnt0));

  branch_select_check #(.WIDTH(5), .NUM_COND(3), .SEL_W(2), .FLUSH_CYCLES(4), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .valid_in(vi), .ready_out(rdy1),
    .instruct(ins), .enabled(en), .cond_mode(mode), .cond_sel(sel),
    .cond_inv(inv), .cond_flags(flags[2:0]), .instructA(ia1), .valid_out(vo1),
    .taken(tk1), .flush(fl1), .taken_count(cnt1));

  // ---------------- behavioural model ----------------
  localparam int MW [2] = '{2, 5};
  localparam int MNC[2] = '{4, 3};
  localparam int MFL[2] = '{2, 4};
  localparam int MCW[2] = '{8, 3};

  logic [4:0] m_ia [2] = '{5'd0, 5'd0};
  bit         m_vo [2] = '{0, 0};
  bit         m_tk [2] = '{0, 0};
  int         m_fl [2] = '{0, 0};   // flush cycles still to come
  int         m_cnt[2] = '{0, 0};

  function automatic bit jump_of(int nc);
    bit f;
    if (int'(sel) < nc) f = flags[sel] ^ inv;
    else                f = inv;
    return en | (mode & f);
  endfunction

  function automatic logic [4:0] ones(int w);
    return 5'((1 << w) - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_ia[k] <= '0; m_vo[k] <= 0; m_tk[k] <= 0; m_fl[k] <= 0; m_cnt[k] <= 0;
      end else if (vi && m_fl[k] == 0) begin
        m_ia[k] <= (ins | (jump_of(MNC[k]) ? 5'h1f : 5'h00)) & ones(MW[k]);
        m_vo[k] <= 1;
        m_tk[k] <= jump_of(MNC[k]);
        if (jump_of(MNC[k])) begin
          m_fl[k] <= MFL[k];
          if (m_cnt[k] < (1 << MCW[k]) - 1) m_cnt[k] <= m_cnt[k] + 1;
        end
      end else begin
        m_vo[k] <= 0;
        m_tk[k] <= 0;
        if (m_fl[k] > 0) m_fl[k] <= m_fl[k] - 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: both instances against the model on every cycle.
  always @(negedge clk) begin
    chk("u0.instructA", 32'(ia0), 32'(m_ia[0][1:0]));
    chk("u0.valid_out", 32'(vo0), 32'(m_vo[0]));
    chk("u0.taken",     32'(tk0), 32'(m_tk[0]));
    chk("u0.flush",     32'(fl0), 32'(m_fl[0] > 0));
    chk("u0.ready_out", 32'(rdy0), 32'(m_fl[0] == 0));
    chk("u0.count",     32'(cnt0), 32'(m_cnt[0]));
    chk("u1.instructA", 32'(ia1), 32'(m_ia[1]));
    chk("u1.valid_out", 32'(vo1), 32'(m_vo[1]));
    chk("u1.taken",     32'(tk1), 32'(m_tk[1]));
    chk("u1.flush",     32'(fl1), 32'(m_fl[1] > 0));
    chk("u1.ready_out", 32'(rdy1), 32'(m_fl[1] == 0));
    chk("u1.count",     32'(cnt1), 32'(m_cnt[1]));
  end

  // ---------------- directed stimulus ----------------
  // Drive just after a negedge. Return 2 time units after the following posedge.
  task automatic step(bit v, logic [4:0] i, bit e, bit m, logic [1:0] s, bit iv, logic [3:0] f);
    @(negedge clk);
    #1;
    vi = v; ins = i; en = e; mode = m; sel = s; inv = iv; flags = f;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 5'd0, 0, 0, 2'd0, 0, 4'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst ready", 32'(rdy0), 32'd1);
    chk("rst ia", 32'(ia0), 32'd0);
    chk("rst cnt", 32'(cnt1), 32'd0);
    #9 reset = 1'b0;

    // 1. Basic forcing
    step(1, 5'b00001, 0, 0, 2'd0, 0, 4'b0000);
    chk("t1 ia", 32'(ia0), 32'b01);
    chk("t1 vo", 32'(vo0), 32'd1);
    chk("t1 tk", 32'(tk0), 32'd0);
    chk("t1 ready", 32'(rdy0), 32'd1);
    step(1, 5'b00000, 1, 0, 2'd0, 0, 4'b0000);
    chk("t1 jump ia", 32'(ia0), 32'b11);
    chk("t1 jump tk", 32'(tk0), 32'd1);
    chk("t1 flush1", 32'(fl0), 32'd1);
    chk("t1 ready1", 32'(rdy0), 32'd0);
    chk("t1 cnt", 32'(cnt0), 32'd1);
    idle(1);
    chk("t1 flush2", 32'(fl0), 32'd1);
    chk("t1 ready2", 32'(rdy0), 32'd0);
    idle(1);
    chk("t1 flush off", 32'(fl0), 32'd0);
    chk("t1 ready back", 32'(rdy0), 32'd1);
    idle(3);

    // 2. JNO condition
    step(1, 5'b00000, 0, 1, 2'd0, 1, 4'b0000);
    chk("t2 jno ia", 32'(ia0), 32'b11);
    chk("t2 jno tk", 32'(tk0), 32'd1);
    idle(5);
    step(1, 5'b00010, 0, 1, 2'd0, 1, 4'b0001);
    chk("t2 nojump ia", 32'(ia0), 32'b10);
    chk("t2 nojump tk", 32'(tk0), 32'd0);
    step(1, 5'b00000, 0, 1, 2'd3, 0, 4'b1000);
    chk("t2 sel3 u0 ia", 32'(ia0), 32'b11);
    chk("t2 sel3 u1 ia", 32'(ia1), 32'd0);
    chk("t2 sel3 u1 tk", 32'(tk1), 32'd0);
    idle(5);

    // 3. Blocking during flush
    step(1, 5'b00000, 1, 0, 2'd0, 0, 4'b0000);
    step(1, 5'b00010, 0, 0, 2'd0, 0, 4'b0000);
    chk("t3 blk1 vo", 32'(vo0), 32'd0);
    step(1, 5'b00010, 0, 0, 2'd0, 0, 4'b0000);
    chk("t3 blk2 vo", 32'(vo0), 32'd0);
    step(1, 5'b00010, 0, 0, 2'd0, 0, 4'b0000);
    chk("t3 acc vo", 32'(vo0), 32'd1);
    chk("t3 acc ia", 32'(ia0), 32'b10);
    idle(5);

    // 4. Saturation of u1 (3-bit count)
    repeat (6) begin
      step(1, 5'b00000, 1, 0, 2'd0, 0, 4'b0000);
      idle(5);
    end
    chk("t4 u1 sat", 32'(cnt1), 32'd7);
    chk("t4 u0 cnt", 32'(cnt0), 32'd10);
    step(1, 5'b00000, 1, 0, 2'd0, 0, 4'b0000);
    idle(5);
    chk("t4 u1 hold", 32'(cnt1), 32'd7);
    chk("t4 u0 cnt2", 32'(cnt0), 32'd11);

    // 5. Async reset in u1's second flush cycle
    step(1, 5'b00000, 1, 0, 2'd0, 0, 4'b0000);
    vi = 1'b0; en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5 flush", 32'(fl1), 32'd0);
    chk("t5 ready", 32'(rdy1), 32'd1);
    chk("t5 cnt", 32'(cnt1), 32'd0);
    chk("t5 ia", 32'(ia1), 32'd0);
    #1 reset = 1'b0;
    step(1, 5'b00110, 0, 0, 2'd0, 0, 4'b0000);
    chk("t5 post ia", 32'(ia1), 32'b00110);
    chk("t5 post vo", 32'(vo1), 32'd1);
    idle(1);

    // 6. Width and range
    step(1, 5'b00100, 1, 0, 2'd0, 0, 4'b0000);
    chk("t6 force ia", 32'(ia1), 32'b11111);
    idle(5);
    step(1, 5'b00000, 0, 1, 2'd3, 1, 4'b0000);
    chk("t6 range ia", 32'(ia1), 32'b11111);
    chk("t6 range tk", 32'(tk1), 32'd1);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
